// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs symbolic instruction fields into addressed 16-bit words behind a small FIFO
// Optional HALT lock: define INSTR_ENC_HALT_LOCK_EN to block input after a legal HALT is accepted.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 2,
  localparam int FILL_W    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [15:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_imm,
  output logic              err_op,
  output logic [FILL_W-1:0] fill
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  logic [15:0]       instr_mem_q [FIFO_DEPTH];
  logic [15:0]       instr_mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_imm_q, err_imm_d;
  logic              err_op_q, err_op_d;
  logic              lock;

  logic [15:0] word;
  logic        legal_op;
  logic        imm_ok;
  logic        accept;
  logic        push;
  logic        pop;

  // Field packing and legality; imm_ok only matters for the immediate forms.
  always_comb begin
    word     = 16'h0000;
    legal_op = 1'b0;
    imm_ok   = 1'b1;
    case (opcode)
      3'b110: begin
        if (op == 2'b10) begin
          legal_op = 1'b1;
          word     = {3'b110, 2'b10, rn, imm[7:0]};
          imm_ok   = (imm == {{8{imm[7]}}, imm[7:0]});
        end else if (op == 2'b00) begin
          legal_op = 1'b1;
          word     = {3'b110, 2'b00, 3'b000, rd, shift, rm};
        end
      end
      3'b101: begin
        legal_op = 1'b1;
        case (op)
          2'b01:   word = {3'b101, 2'b01, rn, 3'b000, shift, rm};
          2'b11:   word = {3'b101, 2'b11, 3'b000, rd, shift, rm};
          default: word = {3'b101, op, rn, rd, shift, rm};
        endcase
      end
      3'b011, 3'b100: begin
        if (op == 2'b00) begin
          legal_op = 1'b1;
          word     = {opcode, 2'b00, rn, rd, imm[4:0]};
          imm_ok   = (imm == {{11{imm[4]}}, imm[4:0]});
        end
      end
      3'b111: begin
        if (op == 2'b00) begin
          legal_op = 1'b1;
          word     = 16'hE000;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = !reset && !clear && (fill_q < FILL_MAX) && !lock;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal_op && imm_ok;
  assign out_valid = (fill_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    instr_mem_d = instr_mem_q;
    addr_mem_d  = addr_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    addr_d      = addr_q;
    err_imm_d   = err_imm_q;
    err_op_d    = err_op_q;

    if (push) begin
      instr_mem_d[wr_ptr_q] = word;
      addr_mem_d[wr_ptr_q]  = addr_q;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase

    // An illegal pair masks any immediate problem in the same bundle.
    if (accept && !legal_op) begin
      err_op_d = 1'b1;
    end else if (accept && !imm_ok) begin
      err_imm_d = 1'b1;
    end

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
      addr_d    = ADDR_BASE;
      err_imm_d = 1'b0;
      err_op_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_mem_q <= '{default: '0};
      addr_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      addr_q      <= ADDR_BASE;
      err_imm_q   <= 1'b0;
      err_op_q    <= 1'b0;
    end else begin
      instr_mem_q <= instr_mem_d;
      addr_mem_q  <= addr_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      addr_q      <= addr_d;
      err_imm_q   <= err_imm_d;
      err_op_q    <= err_op_d;
    end
  end

`ifdef INSTR_ENC_HALT_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (push && (opcode == 3'b111) && (op == 2'b00)) begin
      lock_d = 1'b1;
    end
    if (clear) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 16'h0000;
  assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign err_imm   = err_imm_q;
  assign err_op    = err_op_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, shift;
  logic [15:0] imm;

  logic        in_ready, out_valid, err_imm, err_op;
  logic [15:0] out_instr;
  logic [7:0]  out_addr;
  logic [1:0]  fill;

  logic        in_ready2, out_valid2, err_imm2, err_op2;
  logic [15:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [1:0]  fill2;

  int n_checks = 0;
  int n_bad    = 0;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_imm(err_imm), .err_op(err_op), .fill(fill)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0), .FIFO_DEPTH(2)) u_w2 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
    .err_imm(err_imm2), .err_op(err_op2), .fill(fill2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f_opc, input logic [1:0] f_op, input logic [2:0] f_rn,
                            input logic [2:0] f_rd, input logic [2:0] f_rm, input logic [1:0] f_sh,
                            input logic [15:0] f_imm);
    opcode = f_opc; op = f_op; rn = f_rn; rd = f_rd; rm = f_rm; shift = f_sh; imm = f_imm;
  endtask

  // Presents one bundle and holds it until accepted (bounded).
  task automatic drive(input logic [2:0] f_opc, input logic [1:0] f_op, input logic [2:0] f_rn,
                       input logic [2:0] f_rd, input logic [2:0] f_rm, input logic [1:0] f_sh,
                       input logic [15:0] f_imm);
    int waited = 0;
    set_fields(f_opc, f_op, f_rn, f_rd, f_rm, f_sh, f_imm);
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp_instr, input logic [7:0] exp_addr);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_instr"}, 32'(out_instr), 32'(exp_instr));
    check_eq({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic exp_lock_rdy;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    repeat (2) tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_fill", 32'(fill), 32'd0);
    check_eq("rst_err_imm", 32'(err_imm), 32'd0);
    check_eq("rst_err_op", 32'(err_op), 32'd0);
    check_eq("rst_out_instr", 32'(out_instr), 32'd0);
    check_eq("rst_out_addr", 32'(out_addr), 32'd0);
    check_eq("rst_in_ready_after", 32'(in_ready), 32'd1);

    // MOV R3,#-5
    drive(3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    pop_check("mov_imm", 16'hD3FB, 8'd0);
    // ADD R2,R1,R0 LSL
    drive(3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'b01, 16'h0000);
    pop_check("add", 16'hA148, 8'd1);

    // MOV #0x80 is out of range: handshake completes, nothing pushed
    drive(3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'd0, 16'h0080);
    check_eq("badimm_fill", 32'(fill), 32'd0);
    check_eq("badimm_err_imm", 32'(err_imm), 32'd1);
    check_eq("badimm_err_op", 32'(err_op), 32'd0);
    drive(3'b011, 2'b00, 3'd6, 3'd5, 3'd0, 2'd0, 16'hFFF0);
    pop_check("ldr", 16'h66B0, 8'd2);

    // Back-pressure: two fit, third sees in_ready low
    drive(3'b110, 2'b00, 3'd0, 3'd4, 3'd7, 2'b10, 16'h0000);
    drive(3'b101, 2'b01, 3'd2, 3'd0, 3'd5, 2'b11, 16'h0000);
    check_eq("full_fill", 32'(fill), 32'd2);
    set_fields(3'b101, 2'b10, 3'd1, 3'd1, 3'd1, 2'd0, 16'h0000);
    in_valid = 1'b1;
    #1;
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    pop_check("drain0", 16'hC097, 8'd3);
    check_eq("drain_head_instr", 32'(out_instr), 32'h0000AA1D);
    check_eq("drain_head_addr", 32'(out_addr), 32'd4);
    // Simultaneous pop (CMP) and push (STR R2,[R1,#15])
    set_fields(3'b100, 2'b00, 3'd1, 3'd2, 3'd0, 2'd0, 16'h000F);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("pushpop_fill", 32'(fill), 32'd1);
    pop_check("str", 16'h814F, 8'd5);
    // MOV #-128 is the lower boundary and legal
    drive(3'b110, 2'b10, 3'd7, 3'd0, 3'd0, 2'd0, 16'hFF80);
    pop_check("mov_min", 16'hD780, 8'd6);
    // STR #16 is just out of range
    drive(3'b100, 2'b00, 3'd1, 3'd2, 3'd0, 2'd0, 16'h0010);
    check_eq("str16_fill", 32'(fill), 32'd0);

    // Illegal opcode
    drive(3'b010, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check_eq("illop_err_op", 32'(err_op), 32'd1);
    check_eq("illop_fill", 32'(fill), 32'd0);
    clear = 1'b1;
    #1;
    check_eq("clear_in_ready", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0;
    #1;
    check_eq("clear_err_op", 32'(err_op), 32'd0);
    check_eq("clear_err_imm", 32'(err_imm), 32'd0);
    // Illegal pair plus bad immediate flags only err_op
    drive(3'b111, 2'b01, 3'd0, 3'd0, 3'd0, 2'd0, 16'h1234);
    check_eq("both_err_op", 32'(err_op), 32'd1);
    check_eq("both_err_imm", 32'(err_imm), 32'd0);

    // Mid-stream clear discards buffered words
    drive(3'b101, 2'b10, 3'd3, 3'd4, 3'd5, 2'd0, 16'h0000);
    drive(3'b101, 2'b10, 3'd3, 3'd4, 3'd5, 2'd0, 16'h0000);
    check_eq("mid_fill", 32'(fill), 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_fill_after", 32'(fill), 32'd0);

    // Address restarts at base; narrow instance wraps
    for (int i = 0; i < 5; i++) begin
      drive(3'b101, 2'b11, 3'd0, 3'(i), 3'd0, 2'd0, 16'h0000);
      check_eq($sformatf("wrap_addr2_%0d", i), 32'(out_addr2), 32'(i % 4));
      pop_check($sformatf("wrap_%0d", i), 16'hB800 | 16'(i << 5), 8'(i));
    end

    // HALT
`ifdef INSTR_ENC_HALT_LOCK_EN
    exp_lock_rdy = 1'b0;
`else
    exp_lock_rdy = 1'b1;
`endif
    drive(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    check_eq("halt_in_ready", 32'(in_ready), 32'(exp_lock_rdy));
    pop_check("halt", 16'hE000, 8'd5);
    tick();
    check_eq("halt_in_ready_later", 32'(in_ready), 32'(exp_lock_rdy));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    check_eq("halt_clear_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
